impix_pixelate_ctrl: RTL and testbench

Avalon-MM controller that pixelizes an 8-bit grayscale image held in HPS SDRAM. The HPS programs source/destination buffers, image size and block size through a CSR slave. The block then walks the image in B×B tiles, reads every pixel of a tile through its Avalon-MM master, and writes the tile mean to every pixel of the same tile in the destination buffer. It sits in the FPGA fabric of impix_system: CSR slave on the HPS lightweight bridge, master on the f2h SDRAM path, clocked by `clk_clk` and reset by `hps_0_h2f_reset_reset_n`/`reset_reset_n`.

---
 rtl/impix_pkg.sv | 31 +++
 rtl/impix_tile_walker.sv | 62 ++++++
 rtl/impix_pixelate_ctrl.sv | 172 +++++++++++++++++
 tb/tb_impix_pixelate_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/impix_pkg.sv
// Shared constants for the pixelate controller: CSR word addresses,
// CTRL/STATUS bit positions and the controller FSM state encoding.
package impix_pkg;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam logic [2:0] CSR_SRC    = 3'd2;
    localparam logic [2:0] CSR_DST    = 3'd3;
    localparam logic [2:0] CSR_WIDTH  = 3'd4;
    localparam logic [2:0] CSR_HEIGHT = 3'd5;
    localparam logic [2:0] CSR_LOG2B  = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_WAIT,
        S_AVG,
        S_WR_REQ,
        S_NEXT,
        S_FIN
    } state_t;

endpackage

// File: rtl/impix_tile_walker.sv
// Tile raster walker: bx/by tile origin and ix/iy in-tile position.
// Ports: init zeroes all counters, pix_step advances ix/iy row-major
// (wrapping at the tile end), tile_step advances the tile raster;
// offset is the byte offset of the current pixel, tile_last flags the
// last pixel of a tile and img_last the last tile of the image.
module impix_tile_walker #(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 12,
    parameter int MAX_LOG2B = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              pix_step,
    input  logic              tile_step,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [2:0]        log2b,
    output logic [ADDR_W-1:0] offset,
    output logic              tile_last,
    output logic              img_last
);

    localparam int IW = MAX_LOG2B;

    logic [DIM_W-1:0] bx, by, bsize, row, col;
    logic [IW-1:0]    ix, iy, bmax;

    assign bsize = DIM_W'(1) << log2b;
    assign bmax  = IW'(bsize - DIM_W'(1));

    assign tile_last = (ix == bmax) && (iy == bmax);
    assign img_last  = (bx + bsize == width) && (by + bsize == height);

    assign row    = by + DIM_W'(iy);
    assign col    = bx + DIM_W'(ix);
    assign offset = ADDR_W'(row) * ADDR_W'(width) + ADDR_W'(col);

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            bx <= '0;
            by <= '0;
            ix <= '0;
            iy <= '0;
        end else if (pix_step) begin
            if (ix == bmax) begin
                ix <= '0;
                iy <= (iy == bmax) ? '0 : iy + IW'(1);
            end else begin
                ix <= ix + IW'(1);
            end
        end else if (tile_step) begin
            if (bx + bsize == width) begin
                bx <= '0;
                by <= by + bsize;
            end else begin
                bx <= bx + bsize;
            end
        end
    end

endmodule

// File: rtl/impix_pixelate_ctrl.sv
// Pixelate controller: CSR slave, control FSM and tile accumulator.
// Ports: clk_clk/reset_reset_n (sync, active-low), avs_* CSR slave
// (readLatency 1), avm_* byte master, irq = done & irq_en.
module impix_pixelate_ctrl
    import impix_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 12,
    parameter int MAX_LOG2B = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [7:0]        avm_writedata,
    input  logic [7:0]        avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic              irq
);

    localparam int SUM_W = 8 + 2 * MAX_LOG2B;

    state_t state, state_n;

    logic [ADDR_W-1:0] src, dst, offset;
    logic [DIM_W-1:0]  width, height, bmask;
    logic [2:0]        log2b;
    logic              irq_en, done, err, busy;
    logic [SUM_W-1:0]  sum, sum_shr;
    logic [7:0]        mean;
    logic [31:0]       rd_mux;
    logic              start_req, cfg_ok;
    logic              pix_step, tile_step, tile_last, img_last;

    // A start is only honoured from IDLE; FIN and running states drop it.
    assign start_req = avs_write && (avs_address == CSR_CTRL)
                    && avs_writedata[CTRL_START] && (state == S_IDLE);

    assign bmask  = (DIM_W'(1) << log2b) - DIM_W'(1);
    assign cfg_ok = (width != '0) && (height != '0)
                 && (log2b != 3'd0) && (32'(log2b) <= MAX_LOG2B)
                 && ((width & bmask) == '0) && ((height & bmask) == '0);

    // Mean of B*B pixels: divide by 2^(2*log2b).
    assign sum_shr = sum >> {log2b, 1'b0};

    assign irq = done & irq_en;

    impix_tile_walker #(
        .ADDR_W    (ADDR_W),
        .DIM_W     (DIM_W),
        .MAX_LOG2B (MAX_LOG2B)
    ) u_walker (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .init      (start_req),
        .pix_step  (pix_step),
        .tile_step (tile_step),
        .width     (width),
        .height    (height),
        .log2b     (log2b),
        .offset    (offset),
        .tile_last (tile_last),
        .img_last  (img_last)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= S_IDLE;
        else                state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (start_req) state_n = S_CHECK;
            S_CHECK:   state_n = cfg_ok ? S_RD_REQ : S_FIN;
            S_RD_REQ:  if (!avm_waitrequest) state_n = S_RD_WAIT;
            S_RD_WAIT: if (avm_readdatavalid)
                           state_n = tile_last ? S_AVG : S_RD_REQ;
            S_AVG:     state_n = S_WR_REQ;
            S_WR_REQ:  if (!avm_waitrequest && tile_last) state_n = S_NEXT;
            S_NEXT:    state_n = img_last ? S_FIN : S_RD_REQ;
            S_FIN:     state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read      = (state == S_RD_REQ);
        avm_write     = (state == S_WR_REQ);
        avm_writedata = mean;
        busy          = (state != S_IDLE) && (state != S_FIN);
        pix_step      = ((state == S_RD_WAIT) && avm_readdatavalid)
                     || ((state == S_WR_REQ) && !avm_waitrequest);
        tile_step     = (state == S_NEXT);
        avm_address   = '0;
        if (state == S_RD_REQ) avm_address = src + offset;
        if (state == S_WR_REQ) avm_address = dst + offset;
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            CSR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
            CSR_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done;
                rd_mux[STAT_ERR]  = err;
            end
            CSR_SRC:    rd_mux = 32'(src);
            CSR_DST:    rd_mux = 32'(dst);
            CSR_WIDTH:  rd_mux = 32'(width);
            CSR_HEIGHT: rd_mux = 32'(height);
            CSR_LOG2B:  rd_mux = 32'(log2b);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            src          <= '0;
            dst          <= '0;
            width        <= '0;
            height       <= '0;
            log2b        <= '0;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            sum          <= '0;
            mean         <= '0;
            avs_readdata <= '0;
        end else begin
            avs_readdata <= rd_mux;
            if (avs_write && (avs_address == CSR_CTRL))
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            if (avs_write && !busy) begin
                unique case (avs_address)
                    CSR_SRC:    src    <= ADDR_W'(avs_writedata);
                    CSR_DST:    dst    <= ADDR_W'(avs_writedata);
                    CSR_WIDTH:  width  <= avs_writedata[DIM_W-1:0];
                    CSR_HEIGHT: height <= avs_writedata[DIM_W-1:0];
                    CSR_LOG2B:  log2b  <= avs_writedata[2:0];
                    default:    ;
                endcase
            end
            // Completion beats a same-cycle W1C of done.
            if (state == S_FIN)
                done <= 1'b1;
            else if (avs_write && (avs_address == CSR_STATUS)
                     && avs_writedata[STAT_DONE])
                done <= 1'b0;
            if (start_req)
                err <= 1'b0;
            else if ((state == S_CHECK) && !cfg_ok)
                err <= 1'b1;
            if ((state == S_CHECK) || (state == S_NEXT))
                sum <= '0;
            else if ((state == S_RD_WAIT) && avm_readdatavalid)
                sum <= sum + SUM_W'(avm_readdata);
            if (state == S_AVG)
                mean <= sum_shr[7:0];
        end
    end

endmodule

// File: tb/tb_impix_pixelate_ctrl.sv
// Directed bench for impix_pixelate_ctrl with a byte-memory slave model.
// Drives CSR sequences, checks results against hand-computed values.
module tb_impix_pixelate_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [7:0]  avm_writedata;
    logic [7:0]  avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        irq;

    impix_pixelate_ctrl dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .irq               (irq)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int passed = 0;

    logic [7:0] mem [0:16383];
    int  rd_cnt = 0, wr_cnt = 0, strobe_cnt = 0;
    bit  rnd = 0;
    bit  p_req = 0, p_rd = 0, p_wait = 0;
    logic [31:0] p_addr = '0;
    logic [7:0]  p_wd = '0, rdata = '0;
    int  dly = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Slave model, evaluated away from the active edge: a request seen
    // at one negedge with waitrequest low was accepted at the next posedge.
    always @(negedge clk_clk) begin
        avm_readdatavalid = 1'b0;
        if (avm_read || avm_write) strobe_cnt++;
        if (avm_read && avm_write) check("rd_wr_together", 1, 0);
        if (p_req && p_wait && reset_reset_n) begin
            check("stall_addr", avm_address, p_addr);
            check("stall_strobe", {avm_read, avm_write}, {p_rd, !p_rd});
            if (!p_rd) check("stall_wdata", avm_writedata, p_wd);
        end
        if (p_req && !p_wait) begin
            if (p_rd) begin
                rd_cnt++;
                rdata = mem[p_addr[13:0]];
                dly = rnd ? int'($urandom_range(1, 5)) : 1;
            end else begin
                wr_cnt++;
                mem[p_addr[13:0]] = p_wd;
            end
        end
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rdata;
            end
        end
        p_req  = avm_read || avm_write;
        p_rd   = avm_read;
        p_addr = avm_address;
        p_wd   = avm_writedata;
        avm_waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        p_wait = avm_waitrequest;
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk_clk);
        avs_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic config_job(input int s, input int d, input int w,
                              input int h, input int l);
        csr_wr(3'd2, 32'(s));
        csr_wr(3'd3, 32'(d));
        csr_wr(3'd4, 32'(w));
        csr_wr(3'd5, 32'(h));
        csr_wr(3'd6, 32'(l));
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            csr_rd(3'd1, st);
            if (st[1]) begin
                ok = 1;
                break;
            end
        end
        check(tag, 32'(ok), 1);
    endtask

    function automatic logic [7:0] exp4(input int i);
        logic [7:0] t [4];
        t = '{8'd4, 8'd12, 8'd101, 8'd0};
        return t[((i / 4) / 2) * 2 + (i % 4) / 2];
    endfunction

    task automatic load_src4();
        logic [7:0] img [16];
        img = '{0, 4, 8, 12, 4, 8, 12, 16,
                100, 100, 0, 0, 100, 104, 0, 3};
        for (int i = 0; i < 16; i++) mem[32'h100 + i] = img[i];
    endtask

    task automatic check_dst4(input int base, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (mem[base + i] !== exp4(i)) bad++;
        check(tag, 32'(bad), 0);
    endtask

    initial begin
        logic [31:0] d;
        int n, bad;
        int sum16;

        for (int i = 0; i < 16384; i++) mem[i] = 8'hAA;

        // reset
        repeat (3) @(negedge clk_clk);
        check("rst_avm_read", 32'(avm_read), 0);
        check("rst_avm_write", 32'(avm_write), 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_readdata", avs_readdata, 0);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        csr_rd(3'd1, d); check("rst_status", d, 0);
        csr_rd(3'd2, d); check("rst_src", d, 0);
        csr_rd(3'd6, d); check("rst_log2b", d, 0);

        // 4x4, B=2, irq enabled, latency checks
        load_src4();
        config_job(32'h100, 32'h200, 4, 4, 1);
        csr_wr(3'd0, 32'h2);
        csr_rd(3'd0, d); check("ctrl_readback", d, 32'h2);
        csr_rd(3'd7, d); check("reg7_zero", d, 0);
        rd_cnt = 0; wr_cnt = 0;
        csr_wr(3'd0, 32'h3);
        check("lat_check_no_read", 32'(avm_read), 0);
        @(negedge clk_clk);
        check("lat_first_read", 32'(avm_read), 1);
        check("first_addr", avm_address, 32'h100);
        n = 0;
        while (!avm_write && n < 50) begin
            @(negedge clk_clk);
            n++;
        end
        check("tile_read_phase_cycles", 32'(n), 9);
        check("first_wr_data", 32'(avm_writedata), 4);
        wait_done("t1_done");
        check_dst4(32'h200, "t1_dst");
        check("t1_rd_cnt", 32'(rd_cnt), 16);
        check("t1_wr_cnt", 32'(wr_cnt), 16);
        csr_rd(3'd1, d); check("t1_status", d, 32'h2);
        check("t1_irq", 32'(irq), 1);
        csr_wr(3'd1, 32'h2);
        check("t1_irq_clr", 32'(irq), 0);

        // bad config: W not a multiple of B
        config_job(32'h100, 32'h200, 6, 4, 2);
        strobe_cnt = 0;
        csr_wr(3'd0, 32'h1);
        wait_done("t2_done");
        csr_rd(3'd1, d); check("t2_status", d, 32'h6);
        check("t2_no_traffic", 32'(strobe_cnt), 0);
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, d); check("t2_err_sticky", d, 32'h4);

        // bad config: LOG2B above the maximum
        config_job(32'h100, 32'h200, 32, 32, 5);
        strobe_cnt = 0;
        csr_wr(3'd0, 32'h1);
        wait_done("t2b_done");
        csr_rd(3'd1, d); check("t2b_status", d, 32'h6);
        check("t2b_no_traffic", 32'(strobe_cnt), 0);
        csr_wr(3'd1, 32'h2);

        // random stalls, 16x8, B=4
        for (int i = 0; i < 128; i++) mem[32'h1000 + i] = 8'($urandom);
        config_job(32'h1000, 32'h2000, 16, 8, 2);
        rd_cnt = 0; wr_cnt = 0;
        rnd = 1;
        csr_wr(3'd0, 32'h1);
        wait_done("t3_done");
        rnd = 0;
        bad = 0;
        for (int ty = 0; ty < 2; ty++)
            for (int tx = 0; tx < 4; tx++) begin
                sum16 = 0;
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++)
                        sum16 += int'(mem[32'h1000 + (ty*4+y)*16 + tx*4+x]);
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++)
                        if (mem[32'h2000 + (ty*4+y)*16 + tx*4+x] !== 8'(sum16 >> 4))
                            bad++;
            end
        check("t3_dst", 32'(bad), 0);
        check("t3_rd_cnt", 32'(rd_cnt), 128);
        check("t3_wr_cnt", 32'(wr_cnt), 128);
        csr_rd(3'd1, d); check("t3_status_err_cleared", d, 32'h2);
        csr_wr(3'd1, 32'h2);
        repeat (10) @(negedge clk_clk);

        // writes and start while busy are ignored
        config_job(32'h100, 32'h300, 4, 4, 1);
        wr_cnt = 0;
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd2, 32'h1000);
        csr_wr(3'd4, 32'd8);
        csr_wr(3'd0, 32'h1);
        wait_done("t4_done");
        check_dst4(32'h300, "t4_dst");
        csr_rd(3'd2, d); check("t4_src_kept", d, 32'h100);
        csr_rd(3'd4, d); check("t4_width_kept", d, 4);
        csr_wr(3'd1, 32'h2);
        repeat (40) @(negedge clk_clk);
        csr_rd(3'd1, d); check("t4_single_completion", d, 0);
        check("t4_wr_cnt", 32'(wr_cnt), 16);

        // in place, 8x8, B=8, all 255
        for (int i = 0; i < 64; i++) mem[32'h3000 + i] = 8'hFF;
        config_job(32'h3000, 32'h3000, 8, 8, 3);
        wr_cnt = 0;
        csr_wr(3'd0, 32'h1);
        wait_done("t5_done");
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[32'h3000 + i] !== 8'hFF) bad++;
        check("t5_dst", 32'(bad), 0);
        check("t5_wr_cnt", 32'(wr_cnt), 64);
        csr_wr(3'd1, 32'h2);

        // reset during the write phase, then a clean rerun
        config_job(32'h100, 32'h400, 4, 4, 1);
        csr_wr(3'd0, 32'h1);
        n = 0;
        while (!avm_write && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        check("t6_saw_write", 32'(avm_write), 1);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        check("t6_rst_write", 32'(avm_write), 0);
        check("t6_rst_read", 32'(avm_read), 0);
        reset_reset_n = 1'b1;
        csr_rd(3'd1, d); check("t6_rst_status", d, 0);
        for (int i = 0; i < 16; i++) mem[32'h400 + i] = 8'hAA;
        config_job(32'h100, 32'h400, 4, 4, 1);
        csr_wr(3'd0, 32'h1);
        wait_done("t6_done");
        check_dst4(32'h400, "t6_dst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
